// File: rtl/sram_controller_pkg.sv
// -----------------------------------------------------------------------------
// sram_controller_pkg
// Shared types and defaults for the SRAM controller: chip word address,
// byte mask and data word types, the controller FSM state enum, the default
// read/write wait-state counts, and a state-decode helper used to derive
// registered chip controls from the next state.
// Ports: none (package).
// -----------------------------------------------------------------------------
package sram_controller_pkg;

  typedef logic [19:0] SramChipAddress_t;
  typedef logic [3:0]  ByteMask_t;
  typedef logic [31:0] Word_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    W_SETUP = 3'd2,
    W_PULSE = 3'd3,
    W_HOLD  = 3'd4,
    DONE    = 3'd5
  } SramCtrlState_t;

  localparam int SRAM_READ_WAIT  = 2;
  localparam int SRAM_WRITE_WAIT = 2;

  // True in every state where the chip must be selected (ce_n low).
  function automatic logic chip_selected(input SramCtrlState_t s);
    logic sel;
    case (s)
      READ, W_SETUP, W_PULSE, W_HOLD: sel = 1'b1;
      default:                        sel = 1'b0;
    endcase
    return sel;
  endfunction

  // True in every state where the controller owns the chip data bus.
  function automatic logic bus_driven(input SramCtrlState_t s);
    logic drv;
    case (s)
      W_SETUP, W_PULSE, W_HOLD: drv = 1'b1;
      default:                  drv = 1'b0;
    endcase
    return drv;
  endfunction

endpackage

// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
// Bus slave that turns single-word bus reads/writes into timed asynchronous
// SRAM cycles. A request is latched in IDLE; reads hold ce_n/oe_n low for
// READ_WAIT cycles and sample the chip in the last one; writes run a one-cycle
// setup, a WRITE_WAIT-cycle we_n pulse and a one-cycle hold. Every access ends
// in a one-cycle DONE state where stall drops and the bus is released.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   address[31:0]         bus byte address, [21:2] is the chip word address
//   read, write           request strobes, held by the master while stall=1
//   data_wr[31:0]         write data
//   mask[3:0]             write byte enables (bit i = byte i)
//   stall                 high while the presented request is incomplete
//   data_rd[31:0]         last read data, fresh in the cycle stall falls
//   data_rd_2[31:0]       unused, constant 0
//   sram_address[19:0]    chip word address
//   sram_data[31:0]       chip data bus (driven only in write states)
//   sram_be_n[3:0]        chip byte enables, active low
//   sram_ce_n/oe_n/we_n   chip controls, active low
// -----------------------------------------------------------------------------
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int READ_WAIT  = SRAM_READ_WAIT,
  parameter int WRITE_WAIT = SRAM_WRITE_WAIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] data_wr,
  input  logic [3:0]  mask,
  output logic        stall,
  output logic [31:0] data_rd,
  output logic [31:0] data_rd_2,
  output logic [19:0] sram_address,
  inout  wire  [31:0] sram_data,
  output logic [3:0]  sram_be_n,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n
);

  localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] WRITE_LAST = CNT_W'(WRITE_WAIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  SramCtrlState_t   state_r, state_next_s;
  logic [CNT_W-1:0] cnt_r, cnt_next_s;
  logic             accept_s;
  logic             rd_sample_s;

  SramChipAddress_t addr_r;
  Word_t            data_r;
  ByteMask_t        be_n_r;
  Word_t            rd_r;
  logic             ce_n_r, oe_n_r, we_n_r, drive_r;

  // Next-state and wait-counter logic; write wins when both strobes are high.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    accept_s     = 1'b0;
    rd_sample_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (write) begin
          state_next_s = W_SETUP;
          accept_s     = 1'b1;
        end else if (read) begin
          state_next_s = READ;
          accept_s     = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      READ: begin
        if (cnt_r == READ_LAST) begin
          state_next_s = DONE;
          cnt_next_s   = '0;
          rd_sample_s  = 1'b1;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      W_SETUP: state_next_s = W_PULSE;
      W_PULSE: begin
        if (cnt_r == WRITE_LAST) begin
          state_next_s = W_HOLD;
          cnt_next_s   = '0;
        end else begin
          cnt_next_s = cnt_r + CNT_ONE;
        end
      end
      W_HOLD: state_next_s = DONE;
      DONE:   state_next_s = IDLE;
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = '0;
      end
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Request latch: address, data and byte enables stay fixed for the access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r <= 20'h0_0000;
      data_r <= 32'h0000_0000;
      be_n_r <= 4'hF;
    end else if (accept_s) begin
      addr_r <= address[21:2];
      data_r <= data_wr;
      be_n_r <= write ? ~mask : 4'h0;
    end
  end

  // Read data capture on the last wait cycle of a read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_r <= 32'h0000_0000;
    end else if (rd_sample_s) begin
      rd_r <= sram_data;
    end
  end

  // Chip controls are registered from the next state so each pin is glitch-free
  // and valid for the whole cycle the FSM spends in that state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_n_r  <= 1'b1;
      oe_n_r  <= 1'b1;
      we_n_r  <= 1'b1;
      drive_r <= 1'b0;
    end else begin
      ce_n_r  <= ~chip_selected(state_next_s);
      oe_n_r  <= (state_next_s != READ);
      we_n_r  <= (state_next_s != W_PULSE);
      drive_r <= bus_driven(state_next_s);
    end
  end

  assign sram_data    = drive_r ? data_r : 32'hzzzz_zzzz;
  assign sram_address = addr_r;
  assign sram_be_n    = be_n_r;
  assign sram_ce_n    = ce_n_r;
  assign sram_oe_n    = oe_n_r;
  assign sram_we_n    = we_n_r;

  assign stall     = (read | write) && (state_r != DONE);
  assign data_rd   = rd_r;
  assign data_rd_2 = 32'h0000_0000;

endmodule

// File: tb/tb_sram_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_controller
// Self-checking bench for sram_controller: a simple asynchronous SRAM chip
// model, a bus master driving directed and random accesses, a word-level
// reference memory, and one compare process that checks stall, chip pins and
// read data every cycle from the access timing rules.
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_sram_controller;

  localparam int RW = 2;
  localparam int WW = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] address = 32'h0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] data_wr = 32'h0;
  logic [3:0]  mask = 4'h0;
  logic        stall;
  logic [31:0] data_rd;
  logic [31:0] data_rd_2;
  logic [19:0] sram_address;
  wire  [31:0] sram_data;
  logic [3:0]  sram_be_n;
  logic        sram_ce_n, sram_oe_n, sram_we_n;

  sram_controller #(.READ_WAIT(RW), .WRITE_WAIT(WW)) dut (
    .clk(clk), .rst_n(rst_n), .address(address), .read(read), .write(write),
    .data_wr(data_wr), .mask(mask), .stall(stall), .data_rd(data_rd),
    .data_rd_2(data_rd_2), .sram_address(sram_address), .sram_data(sram_data),
    .sram_be_n(sram_be_n), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return 32'hC0DE_0000 | 32'(i * 37);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // SRAM chip model: 64 words, drives the bus on an enabled read, writes
  // enabled bytes while we_n is low.
  logic [31:0] chip_mem [64];
  assign sram_data = (!sram_ce_n && !sram_oe_n && sram_we_n) ? chip_mem[sram_address[5:0]] : 32'hzzzz_zzzz;

  initial begin
    for (int i = 0; i < 64; i++) chip_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (!sram_ce_n && !sram_we_n)
        for (int b = 0; b < 4; b++)
          if (!sram_be_n[b]) chip_mem[sram_address[5:0]][8*b +: 8] = sram_data[8*b +: 8];
    end
  end

  // Cycle counter (cycle N starts at the N-th rising edge).
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Current access as seen by the reference model (owned by the driver).
  logic        t_active = 1'b0;
  logic        t_wr = 1'b0;
  int          t_start = 0;
  logic [19:0] t_addr = 20'h0;
  logic [31:0] t_data = 32'h0;
  logic [3:0]  t_be = 4'h0;
  logic [31:0] t_exp = 32'h0;

  logic [31:0] last_rd = 32'h0;
  int          stall_cycles = 0;
  int          we_low_cycles = 0;
  int          c_idx, c_lat;

  // Compare process: every cycle, derive what the pins must be from the
  // position inside the current access.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_rd = 32'h0;
    end else if (t_active) begin
      c_idx = cyc - t_start;
      c_lat = t_wr ? (3 + WW) : (1 + RW);
      chk("stall", 32'(stall), 32'((read | write) && (c_idx < c_lat)));
      if (stall) stall_cycles++;
      if (!sram_we_n) we_low_cycles++;
      if (c_idx >= 1 && c_idx < c_lat) begin
        chk("ce_n_active", 32'(sram_ce_n), 32'h0);
        chk("sram_address", 32'(sram_address), 32'(t_addr));
        chk("sram_be_n", 32'(sram_be_n), 32'(t_be));
        if (t_wr) begin
          chk("oe_n_write", 32'(sram_oe_n), 32'h1);
          chk("we_n_write", 32'(sram_we_n), 32'((c_idx >= 2 && c_idx < 2 + WW) ? 0 : 1));
          chk("sram_data_write", sram_data, t_data);
        end else begin
          chk("oe_n_read", 32'(sram_oe_n), 32'h0);
          chk("we_n_read", 32'(sram_we_n), 32'h1);
        end
      end else begin
        chk("ctrl_idle", {29'h0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
      end
      if (c_idx == c_lat && !t_wr) begin
        chk("data_rd_done", data_rd, t_exp);
        last_rd = t_exp;
      end else begin
        chk("data_rd_hold", data_rd, last_rd);
      end
    end else begin
      chk("stall_idle", 32'(stall), 32'h0);
      chk("ctrl_idle", {29'h0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
      chk("data_rd_hold", data_rd, last_rd);
    end
  end

  // Driver and reference memory.
  logic [31:0] ref_mem [64];
  logic [19:0] cap_addr;
  logic [3:0]  cap_be;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_txn(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] m);
    t_wr   = wr;
    t_addr = a[21:2];
    t_data = d;
    t_be   = wr ? ~m : 4'h0;
    if (wr) ref_mem[a[7:2]] = merge(ref_mem[a[7:2]], d, m);
    else    t_exp = ref_mem[a[7:2]];
    t_start = cyc;
    t_active = 1'b1;
    stall_cycles = 0;
    we_low_cycles = 0;
    read = rd; write = wr; address = a; data_wr = d; mask = m;
  endtask

  // One full access; drop_at>0 releases the strobes in that cycle. Bus inputs
  // are scrambled after acceptance to show the access uses latched values.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m, input int drop_at);
    int lat;
    lat = wr ? (3 + WW) : (1 + RW);
    start_txn(rd, wr, a, d, m);
    for (int k = 1; k <= lat; k++) begin
      tick();
      if (k == 1) begin
        cap_addr = sram_address;
        cap_be   = sram_be_n;
      end
      if (k == drop_at) begin
        read = 1'b0; write = 1'b0;
      end
      address = $urandom; data_wr = $urandom; mask = 4'($urandom);
    end
    tick();
    read = 1'b0; write = 1'b0;
    t_active = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[21:8] = 14'h0;
    return a;
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);

    // Reset values.
    tick(); tick();
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_ctrl", {29'h0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
    chk("rst_be_n", 32'(sram_be_n), 32'hF);
    chk("rst_address", 32'(sram_address), 32'h0);
    chk("rst_data_rd", data_rd, 32'h0);
    chk("data_rd_2", data_rd_2, 32'h0);
    rst_n = 1'b1;
    tick(); tick();

    // Write then read 0x10.
    run_txn(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, -1);
    chk("wr_sram_address", 32'(cap_addr), 32'h0000_0004);
    chk("wr_stall_cycles", 32'(stall_cycles), 32'd5);
    chk("wr_we_low_cycles", 32'(we_low_cycles), 32'd2);
    tick();
    run_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, -1);
    chk("rd_stall_cycles", 32'(stall_cycles), 32'd3);
    chk("rd_deadbeef", data_rd, 32'hDEAD_BEEF);

    // Byte write on top of a preload.
    run_txn(1'b0, 1'b1, 32'h0000_0040, 32'h1122_3344, 4'hF, -1);
    run_txn(1'b0, 1'b1, 32'h0000_0040, 32'hAABB_CCDD, 4'b0101, -1);
    chk("byte_be_n", 32'(cap_be), 32'hA);
    run_txn(1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, -1);
    chk("byte_readback", data_rd, 32'h11BB_33DD);

    // Simultaneous read and write is a write.
    tick();
    run_txn(1'b1, 1'b1, 32'h0000_0020, 32'h0000_0005, 4'hF, -1);
    chk("rw_stall_cycles", 32'(stall_cycles), 32'd5);
    run_txn(1'b1, 1'b0, 32'h0000_0020, 32'h0, 4'h0, -1);
    chk("rw_readback", data_rd, 32'h0000_0005);

    // Read dropped in cycle 1 still completes.
    tick();
    run_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 1);
    chk("drop_readback", data_rd, 32'hDEAD_BEEF);

    // Four back-to-back reads.
    for (int i = 0; i < 4; i++) run_txn(1'b1, 1'b0, 32'(i * 4), 32'h0, 4'h0, -1);
    chk("b2b_last", data_rd, init_word(3));

    // Zero mask write leaves the word unchanged.
    run_txn(1'b0, 1'b1, 32'h0000_0044, 32'hFFFF_FFFF, 4'h0, -1);
    chk("mask0_be_n", 32'(cap_be), 32'hF);
    run_txn(1'b1, 1'b0, 32'h0000_0044, 32'h0, 4'h0, -1);
    chk("mask0_readback", data_rd, init_word(17));

    // Reset in the middle of the write pulse.
    tick();
    start_txn(1'b0, 1'b1, 32'h0000_0080, 32'h1234_5678, 4'hF);
    tick(); tick();
    @(negedge clk);
    #1;
    rst_n = 1'b0; read = 1'b0; write = 1'b0; t_active = 1'b0;
    #1;
    chk("abort_ctrl", {29'h0, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
    chk("abort_be_n", 32'(sram_be_n), 32'hF);
    chk("abort_data_rd", data_rd, 32'h0);
    chk("abort_stall", 32'(stall), 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_stall", 32'(stall), 32'h0);
    run_txn(1'b1, 1'b0, 32'h0000_0080, 32'h0, 4'h0, -1);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      int op, drop, gap;
      op   = $urandom_range(0, 3);
      drop = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : -1;
      run_txn((op == 0 || op == 2 || op == 3), (op == 1 || op == 2), rand_addr(),
              $urandom, 4'($urandom), drop);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) tick();
    end
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
